// File: rtl/dsp_accum_pkg.sv
// Shared types, default widths and helpers for the DSP product accumulator.
package dsp_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned PW_DEF   = 48;
  localparam int unsigned AW_DEF   = 56;
  localparam int unsigned CNTW_DEF = 8;
  localparam int unsigned SAT_MAXW = 64;

  // All-ones value of width aw, right-aligned in a SAT_MAXW-bit word (aw <= SAT_MAXW).
  function automatic logic [SAT_MAXW-1:0] sat_max(input int unsigned aw);
    return {SAT_MAXW{1'b1}} >> (SAT_MAXW - aw);
  endfunction

endpackage

// File: rtl/dsp_prod_accum_if.sv
// Product-in / frame-sum-out handshake bundle for dsp_prod_accum.
interface dsp_prod_accum_if #(
  parameter int unsigned PW   = dsp_accum_pkg::PW_DEF,
  parameter int unsigned AW   = dsp_accum_pkg::AW_DEF,
  parameter int unsigned CNTW = dsp_accum_pkg::CNTW_DEF
);
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   in_p;
  logic [CNTW-1:0] frame_len;
  logic            clear;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_sum;
  logic            out_ovf;
  logic            busy;

  modport master (
    output in_valid, in_p, frame_len, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_p, frame_len, clear, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/dsp_sat_add.sv
// Combinational unsigned saturating adder; sticky_in forces the saturated result.
module dsp_sat_add
  import dsp_accum_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  input  logic          sticky_in,
  output logic [AW-1:0] sum,
  output logic          ovf
);
  localparam logic [AW-1:0] SAT = AW'(sat_max(AW));

  logic [AW:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[AW] | sticky_in;
    sum  = ovf ? SAT : full[AW-1:0];
  end
endmodule

// File: rtl/dsp_prod_accum.sv
// Sums a programmable-length frame of multiplier products with sticky saturation
// and presents the result on a valid/ready output.
module dsp_prod_accum
  import dsp_accum_pkg::*;
#(
  parameter int unsigned PW   = PW_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dsp_prod_accum_if.slave  bus
);
  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   out_sum_q, out_sum_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] len_q, len_d;
  logic            ovf_q, ovf_d;
  logic            out_ovf_q, out_ovf_d;

  logic [PW-1:0]   in_p;
  logic [AW-1:0]   in_p_ext;
  logic [AW-1:0]   add_sum;
  logic            add_ovf;
  logic [CNTW-1:0] cnt_inc;
  logic [CNTW-1:0] len_first;
  logic            in_ready;
  logic            accept;

  assign in_p      = bus.in_p;
  assign in_p_ext  = AW'(in_p);
  assign in_ready  = !bus.clear && (state_q != HOLD);
  assign accept    = bus.in_valid && in_ready;
  assign cnt_inc   = cnt_q + 1'b1;
  assign len_first = (bus.frame_len == '0) ? CNTW'(1) : bus.frame_len;

  dsp_sat_add #(.AW(AW)) u_add (
    .a        (acc_q),
    .b        (in_p_ext),
    .sticky_in(ovf_q),
    .sum      (add_sum),
    .ovf      (add_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          len_d = len_first;
          if (len_first == CNTW'(1)) begin
            state_d   = HOLD;
            out_sum_d = in_p_ext;
            out_ovf_d = 1'b0;
          end else begin
            state_d = ACC;
            acc_d   = in_p_ext;
            cnt_d   = CNTW'(1);
            ovf_d   = 1'b0;
          end
        end
      end

      ACC: begin
        if (bus.clear) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d   = HOLD;
            out_sum_d = add_sum;
            out_ovf_d = add_ovf;
          end else begin
            acc_d = add_sum;
            ovf_d = add_ovf;
          end
        end
      end

      HOLD: begin
        // clear is ignored here: the pending result must be consumed first.
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dsp_prod_accum.sv
// Directed bench for dsp_prod_accum: table of frames plus backpressure, clear,
// saturation (AW=50 instance) and async reset sequences.
module tb_dsp_prod_accum;

  typedef struct packed {
    logic [7:0]        len;
    int unsigned       nbeats;
    logic [3:0][47:0]  p;
    logic [55:0]       exp_sum;
    logic              exp_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t        vecs [6];
  vec_t        v;

  dsp_prod_accum_if #(.PW(48), .AW(56), .CNTW(8)) bus ();
  dsp_prod_accum_if #(.PW(48), .AW(50), .CNTW(8)) bus50 ();

  dsp_prod_accum #(.PW(48), .AW(56), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  dsp_prod_accum #(.PW(48), .AW(50), .CNTW(8)) dut50 (
    .clk(clk), .rst(rst), .bus(bus50)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beats go back-to-back; frame_len is scrambled after the first beat to show it is ignored.
  task automatic run_vec(input vec_t t);
    for (int unsigned b = 0; b < t.nbeats; b++) begin
      bus.in_valid  = 1'b1;
      bus.in_p      = t.p[b];
      bus.frame_len = (b == 0) ? t.len : ~t.len;
      #1;
      check("in_ready_beat", {63'd0, bus.in_ready}, 64'd1);
      tick();
      if (b + 1 < t.nbeats) begin
        check("out_valid_mid", {63'd0, bus.out_valid}, 64'd0);
        check("busy_mid", {63'd0, bus.busy}, 64'd1);
      end
    end
    bus.in_valid = 1'b0;
    check("out_valid_done", {63'd0, bus.out_valid}, 64'd1);
    check("out_sum", {8'd0, bus.out_sum}, {8'd0, t.exp_sum});
    check("out_ovf", {63'd0, bus.out_ovf}, {63'd0, t.exp_ovf});
    check("in_ready_hold", {63'd0, bus.in_ready}, 64'd0);
    tick();
    check("out_valid_after", {63'd0, bus.out_valid}, 64'd0);
    check("busy_after", {63'd0, bus.busy}, 64'd0);
    check("in_ready_after", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_p = '0; bus.frame_len = '0; bus.clear = 0; bus.out_ready = 1;
    bus50.in_valid = 0; bus50.in_p = '0; bus50.frame_len = '0; bus50.clear = 0; bus50.out_ready = 1;

    vecs[0] = '{len: 8'd4, nbeats: 4, p: {48'd837, 48'd837, 48'd837, 48'd837},
                exp_sum: 56'd3348, exp_ovf: 1'b0};
    vecs[1] = '{len: 8'd0, nbeats: 1, p: {48'd0, 48'd0, 48'd0, 48'd396},
                exp_sum: 56'd396, exp_ovf: 1'b0};
    vecs[2] = '{len: 8'd1, nbeats: 1, p: {48'd0, 48'd0, 48'd0, 48'd837},
                exp_sum: 56'd837, exp_ovf: 1'b0};
    vecs[3] = '{len: 8'd2, nbeats: 2, p: {48'd0, 48'd0, 48'd5, 48'd5},
                exp_sum: 56'd10, exp_ovf: 1'b0};
    vecs[4] = '{len: 8'd3, nbeats: 3, p: {48'd0, 48'd396, 48'd0, 48'd396},
                exp_sum: 56'd792, exp_ovf: 1'b0};
    vecs[5] = '{len: 8'd2, nbeats: 2, p: {48'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF},
                exp_sum: 56'h1_FFFF_FFFF_FFFE, exp_ovf: 1'b0};

    // Reset state
    #3;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_sum", {8'd0, bus.out_sum}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_out_ovf", {63'd0, bus.out_ovf}, 64'd0);
    rst = 1'b1;
    tick();
    check("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure: result held 5 cycles; a waiting beat is not taken during HOLD.
    bus.out_ready = 1'b0;
    bus.frame_len = 8'd3;
    for (int b = 0; b < 3; b++) begin
      bus.in_valid = 1'b1;
      bus.in_p     = (b == 1) ? 48'd0 : 48'd396;
      tick();
    end
    bus.in_p = 48'd7;
    bus.frame_len = 8'd1;
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_out_sum", {8'd0, bus.out_sum}, 64'd792);
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    check("bp_hs_in_ready", {63'd0, bus.in_ready}, 64'd0);
    tick();
    check("bp_release_valid", {63'd0, bus.out_valid}, 64'd0);
    check("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_next_valid", {63'd0, bus.out_valid}, 64'd1);
    check("bp_next_sum", {8'd0, bus.out_sum}, 64'd7);
    tick();
    check("bp_next_idle", {63'd0, bus.busy}, 64'd0);

    // Saturation on the AW=50 instance: 8 x (2^48-1) exceeds 2^50-1.
    bus50.frame_len = 8'd8;
    bus50.in_p = 48'hFFFF_FFFF_FFFF;
    for (int b = 0; b < 8; b++) begin
      bus50.in_valid = 1'b1;
      tick();
      if (b < 7) check("sat_mid_valid", {63'd0, bus50.out_valid}, 64'd0);
    end
    bus50.in_valid = 1'b0;
    check("sat_valid", {63'd0, bus50.out_valid}, 64'd1);
    check("sat_sum", {14'd0, bus50.out_sum}, 64'h3_FFFF_FFFF_FFFF);
    check("sat_ovf", {63'd0, bus50.out_ovf}, 64'd1);
    tick();
    bus50.frame_len = 8'd2;
    bus50.in_p = 48'd1;
    for (int b = 0; b < 2; b++) begin
      bus50.in_valid = 1'b1;
      tick();
    end
    bus50.in_valid = 1'b0;
    check("sat_next_sum", {14'd0, bus50.out_sum}, 64'd2);
    check("sat_next_ovf", {63'd0, bus50.out_ovf}, 64'd0);
    tick();

    // Clear mid-frame with a simultaneous beat.
    bus.frame_len = 8'd4;
    bus.in_p = 48'd100;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1;
      tick();
    end
    bus.clear = 1'b1;
    #1;
    check("clr_in_ready", {63'd0, bus.in_ready}, 64'd0);
    tick();
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_busy", {63'd0, bus.busy}, 64'd0);
    check("clr_out_valid", {63'd0, bus.out_valid}, 64'd0);
    v = '{len: 8'd2, nbeats: 2, p: {48'd0, 48'd0, 48'd5, 48'd5}, exp_sum: 56'd10, exp_ovf: 1'b0};
    run_vec(v);

    // Asynchronous reset mid-frame.
    bus.frame_len = 8'd4;
    bus.in_p = 48'd100;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    check("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_out_sum", {8'd0, bus.out_sum}, 64'd0);
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_out_ovf", {63'd0, bus.out_ovf}, 64'd0);
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    #2 rst = 1'b1;
    tick();
    v = '{len: 8'd1, nbeats: 1, p: {48'd0, 48'd0, 48'd0, 48'd837}, exp_sum: 56'd837, exp_ovf: 1'b0};
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_prod_accum.md
Name: dsp_prod_accum

Overview:
- Downstream consumer of the iCE40 DSP multiplier stage.
- Takes one unsigned 48-bit product p per accepted beat and sums a programmable-length frame of products with saturation.
- Presents the frame sum on a valid/ready output with backpressure.
- Sits between the multiplier `top` and the result sink.

Parameters:
- PW, 48, product (input) width; matches multiplier p output.
- AW, 56, accumulator/output width; AW >= PW required.
- CNTW, 8, frame-length counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- in_p  input  PW  unsigned product from multiplier.
- frame_len  input  CNTW  products per frame; sampled on first beat of a frame.
- clear  input  1  synchronous abort of current frame.
- out_valid  output  1  frame sum available.
- out_ready  input  1  sink accepts sum.
- out_sum  output  AW  saturated frame sum.
- out_ovf  output  1  saturation occurred in this frame.
- busy  output  1  frame in progress or result pending.

Behaviour:
- Reset (rst low, async): state IDLE, acc=0, cnt=0, len_q=0, out_valid=0, out_sum=0, out_ovf=0, busy=0. Effect is immediate, mid-frame included; partial frame discarded.
- Accept = in_valid && in_ready.
- in_ready = !clear && state != HOLD. Combinational, with no dependence on in_valid.
- States:
  - IDLE: on accept, len_q <= (frame_len==0 ? 1 : frame_len). If len_q==1, go HOLD with out_sum=in_p, out_ovf=0. Otherwise go ACC with acc=in_p, cnt=1.
  - ACC: on accept, sum = acc + in_p, computed in AW+1 bits. If the carry is set or ovf_q is set, the result is {AW{1'b1}} and ovf_q=1. cnt increments. If cnt+1 == len_q, go HOLD, latch out_sum=result and out_ovf=ovf; otherwise stay in ACC with acc=result.
  - HOLD: out_valid=1; out_sum/out_ovf stable. When out_ready, go IDLE at the next edge; out_valid=0 and acc/cnt/ovf_q are cleared.
- Latency: the final beat accepted at edge N gives out_valid=1 immediately after edge N. There is no combinational path from in_* to out_*.
- HOLD never overlaps the next frame's first beat; in_ready is 0 for the whole HOLD cycle, including the handshake cycle.
- frame_len changes mid-frame are ignored; len_q is used.
- clear in IDLE/ACC: next state IDLE, acc/cnt/ovf_q=0. A simultaneous in_valid beat is not accepted, because in_ready=0.
- clear in HOLD: ignored; the pending result must be consumed.
- Saturation is sticky within a frame. out_sum never wraps.
- busy = (state != IDLE).
- Arithmetic is unsigned. in_p is zero-extended to AW bits.

Decomposition:
- Package dsp_accum_pkg holds:
  - state enum state_t {IDLE, ACC, HOLD};
  - default width localparams PW_DEF=48, AW_DEF=56, CNTW_DEF=8;
  - function sat_max(AW).
- One sub-module, dsp_sat_add:
  - combinational AW-bit unsigned saturating adder;
  - ports a, b, sticky_in -> sum, ovf.
- The FSM, counter and output register stay in dsp_prod_accum.

Test Plan:
1. frame_len=4, four beats in_p=837 (38*22+1), out_ready=1 -> out_valid one cycle after 4th accept, out_sum=3348, out_ovf=0, then IDLE and in_ready=1.
2. frame_len=3, beats 396/0/396, out_ready held low 5 cycles -> out_sum=792 stable, out_valid=1, in_ready=0 throughout. Release out_ready -> out_valid=0 next cycle.
3. frame_len=0, single beat in_p=396 (33*12) -> treated as length 1; out_sum=396 after that edge.
4. AW=50 override, frame_len=8, in_p=48'hFFFF_FFFF_FFFF each beat -> out_sum=50'h3_FFFF_FFFF_FFFF, out_ovf=1. The next frame (len 2, 1+1) gives out_sum=2, out_ovf=0.
5. frame_len=4, 2 beats of 100, then clear=1 with in_valid=1 -> beat not accepted, state IDLE. New frame len 2 of 5+5 -> out_sum=10.
6. Drop rst mid-frame after 2 beats, then release -> all outputs 0 immediately. Subsequent frame len 1, in_p=837 -> out_sum=837.
